// File: rtl/gnrl_bitmap_64rel4_module.sv
// Free-entry bitmap for the 64-to-4 select encoder: clears allocated bits, sets
// released bits, and keeps a registered popcount plus sticky misuse flags.
module gnrl_bitmap_64rel4_module #(
  parameter logic [63:0] RST_VALUE  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned RDY_THRESH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [3:0]  i_alloc_vld,
  input  logic [5:0]  i_alloc_idx_0,
  input  logic [5:0]  i_alloc_idx_1,
  input  logic [5:0]  i_alloc_idx_2,
  input  logic [5:0]  i_alloc_idx_3,
  input  logic [3:0]  i_rel_vld,
  input  logic [5:0]  i_rel_idx_0,
  input  logic [5:0]  i_rel_idx_1,
  input  logic [5:0]  i_rel_idx_2,
  input  logic [5:0]  i_rel_idx_3,
  output logic [63:0] o_free_map,
  output logic [6:0]  o_free_cnt,
  output logic        o_alloc_rdy,
  output logic        o_err_dbl_rel,
  output logic        o_err_bad_alloc
);

  function automatic logic [6:0] popcnt(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

  localparam logic [6:0] RST_CNT      = popcnt(RST_VALUE);
  localparam logic [6:0] RDY_THRESH_C = 7'(RDY_THRESH);

  logic [5:0]  alloc_idx    [4];
  logic [5:0]  rel_idx      [4];
  logic [63:0] alloc_onehot [4];
  logic [63:0] rel_onehot   [4];
  logic [63:0] alloc_mask;
  logic [63:0] rel_mask;

  logic [63:0] map_reg, map_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic        err_dbl_rel_reg, err_bad_alloc_reg;
  logic        dbl_rel_hit, bad_alloc_hit;

  assign alloc_idx[0] = i_alloc_idx_0;
  assign alloc_idx[1] = i_alloc_idx_1;
  assign alloc_idx[2] = i_alloc_idx_2;
  assign alloc_idx[3] = i_alloc_idx_3;
  assign rel_idx[0]   = i_rel_idx_0;
  assign rel_idx[1]   = i_rel_idx_1;
  assign rel_idx[2]   = i_rel_idx_2;
  assign rel_idx[3]   = i_rel_idx_3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign alloc_onehot[gi] = i_alloc_vld[gi] ? (64'd1 << alloc_idx[gi]) : 64'd0;
      assign rel_onehot[gi]   = i_rel_vld[gi]   ? (64'd1 << rel_idx[gi])   : 64'd0;
    end
  endgenerate

  assign alloc_mask = alloc_onehot[0] | alloc_onehot[1] | alloc_onehot[2] | alloc_onehot[3];
  assign rel_mask   = rel_onehot[0]   | rel_onehot[1]   | rel_onehot[2]   | rel_onehot[3];

  // Release wins over allocation so an alloc+release of one index leaves it free.
  assign map_next = i_flush ? RST_VALUE : ((map_reg & ~alloc_mask) | rel_mask);
  assign cnt_next = popcnt(map_next);

  always_comb begin
    dbl_rel_hit   = 1'b0;
    bad_alloc_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (i_alloc_vld[k]) begin
        if (!map_reg[alloc_idx[k]]) bad_alloc_hit = 1'b1;
        for (int j = 0; j < 4; j++)
          if (j != k && i_alloc_vld[j] && alloc_idx[j] == alloc_idx[k]) bad_alloc_hit = 1'b1;
      end
      if (i_rel_vld[k]) begin
        // A bit made busy this same cycle may legally come straight back.
        if (map_reg[rel_idx[k]] && !alloc_mask[rel_idx[k]]) dbl_rel_hit = 1'b1;
        for (int j = 0; j < 4; j++)
          if (j != k && i_rel_vld[j] && rel_idx[j] == rel_idx[k]) dbl_rel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      map_reg           <= RST_VALUE;
      cnt_reg           <= RST_CNT;
      err_dbl_rel_reg   <= 1'b0;
      err_bad_alloc_reg <= 1'b0;
    end else begin
      map_reg <= map_next;
      cnt_reg <= cnt_next;
      if (!i_flush) begin
        if (dbl_rel_hit)   err_dbl_rel_reg   <= 1'b1;
        if (bad_alloc_hit) err_bad_alloc_reg <= 1'b1;
      end
    end
  end

  assign o_free_map      = map_reg;
  assign o_free_cnt      = cnt_reg;
  assign o_alloc_rdy     = (cnt_reg >= RDY_THRESH_C);
  assign o_err_dbl_rel   = err_dbl_rel_reg;
  assign o_err_bad_alloc = err_bad_alloc_reg;

endmodule

// File: tb/tb_gnrl_bitmap_64rel4_module.sv
// Bench for the free bitmap: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an index-level model.
module tb_gnrl_bitmap_64rel4_module;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  avld, rvld;
  logic [5:0]  ai [4];
  logic [5:0]  ri [4];
  logic [63:0] free_map;
  logic [6:0]  free_cnt;
  logic        alloc_rdy, err_dbl, err_bad;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [63:0] m_map;
  logic        m_dbl, m_bad;

  always #5 clk = ~clk;

  gnrl_bitmap_64rel4_module dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_alloc_vld(avld),
    .i_alloc_idx_0(ai[0]), .i_alloc_idx_1(ai[1]), .i_alloc_idx_2(ai[2]), .i_alloc_idx_3(ai[3]),
    .i_rel_vld(rvld),
    .i_rel_idx_0(ri[0]), .i_rel_idx_1(ri[1]), .i_rel_idx_2(ri[2]), .i_rel_idx_3(ri[3]),
    .o_free_map(free_map), .o_free_cnt(free_cnt), .o_alloc_rdy(alloc_rdy),
    .o_err_dbl_rel(err_dbl), .o_err_bad_alloc(err_bad)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; flush = 0; avld = 0; rvld = 0;
    for (int k = 0; k < 4; k++) begin ai[k] = 6'($urandom_range(63)); ri[k] = 6'($urandom_range(63)); end
  endtask

  // Apply the rules index by index to the current model state.
  task automatic model_step();
    logic [63:0] nm;
    int same;
    if (rst) begin
      m_map = '1; m_dbl = 0; m_bad = 0;
    end else if (flush) begin
      m_map = '1;
    end else begin
      nm = m_map;
      for (int k = 0; k < 4; k++) if (avld[k]) begin
        same = 0;
        for (int j = 0; j < 4; j++) if (avld[j] && ai[j] == ai[k]) same++;
        if (!m_map[ai[k]] || same > 1) m_bad = 1;
        nm[ai[k]] = 1'b0;
      end
      for (int k = 0; k < 4; k++) if (rvld[k]) begin
        bit allocated_now = 0;
        same = 0;
        for (int j = 0; j < 4; j++) begin
          if (rvld[j] && ri[j] == ri[k]) same++;
          if (avld[j] && ai[j] == ri[k]) allocated_now = 1;
        end
        if ((m_map[ri[k]] && !allocated_now) || same > 1) m_dbl = 1;
      end
      for (int k = 0; k < 4; k++) if (rvld[k]) nm[ri[k]] = 1'b1;
      m_map = nm;
    end
  endtask

  // One clock: advance model, then compare every output just after the edge.
  task automatic cycle();
    int cnt;
    model_step();
    @(posedge clk);
    #1;
    cnt = $countones(m_map);
    chk("map", free_map, m_map);
    chk("cnt", 64'(free_cnt), 64'(cnt));
    chk("rdy", 64'(alloc_rdy), 64'(cnt >= 4));
    chk("err_dbl", 64'(err_dbl), 64'(m_dbl));
    chk("err_bad", 64'(err_bad), 64'(m_bad));
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); idle();
  endtask

  function automatic logic [5:0] pick(input logic [63:0] map, input logic want, input logic [63:0] used);
    int s = $urandom_range(63);
    for (int i = 0; i < 64; i++) begin
      int b = (s + i) % 64;
      if (map[b] == want && !used[b]) return 6'(b);
    end
    return 6'(s);
  endfunction

  initial begin
    m_map = '0; m_dbl = 0; m_bad = 0;
    idle();

    // 1: reset
    do_reset();
    chk("t1_map", free_map, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_cnt", 64'(free_cnt), 64'd64);
    chk("t1_rdy", 64'(alloc_rdy), 64'd1);
    chk("t1_errs", 64'({err_dbl, err_bad}), 64'd0);

    // 2: allocate 0..3
    avld = 4'hF; for (int k = 0; k < 4; k++) ai[k] = 6'(k);
    cycle();
    chk("t2_map", free_map, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("t2_cnt", 64'(free_cnt), 64'd60);

    // 3: drain the rest, then release 10,20,30,40
    for (int c = 1; c < 16; c++) begin
      avld = 4'hF; for (int k = 0; k < 4; k++) ai[k] = 6'(4 * c + k);
      cycle();
    end
    chk("t3_cnt0", 64'(free_cnt), 64'd0);
    chk("t3_rdy0", 64'(alloc_rdy), 64'd0);
    idle(); rvld = 4'hF; ri[0] = 10; ri[1] = 20; ri[2] = 30; ri[3] = 40;
    cycle();
    chk("t3_cnt4", 64'(free_cnt), 64'd4);
    chk("t3_rdy4", 64'(alloc_rdy), 64'd1);
    chk("t3_map", free_map, (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30) | (64'd1 << 40));

    // 4: double release on a free bit, then on two ports at once
    do_reset();
    rvld = 4'h1; ri[0] = 5; cycle();
    chk("t4_dbl_a", 64'(err_dbl), 64'd1);
    chk("t4_map_a", free_map, 64'hFFFF_FFFF_FFFF_FFFF);
    do_reset();
    avld = 4'h1; ai[0] = 7; cycle(); idle();
    rvld = 4'h3; ri[0] = 7; ri[1] = 7; cycle();
    chk("t4_dbl_b", 64'(err_dbl), 64'd1);
    chk("t4_bit7", 64'(free_map[7]), 64'd1);

    // 5: same-cycle alloc+release is legal; duplicate alloc is not
    do_reset();
    avld = 4'h1; ai[0] = 9; rvld = 4'h1; ri[0] = 9; cycle(); idle();
    chk("t5_bit9", 64'(free_map[9]), 64'd1);
    chk("t5_noerr", 64'({err_dbl, err_bad}), 64'd0);
    avld = 4'h3; ai[0] = 9; ai[1] = 9; cycle(); idle();
    chk("t5_bad", 64'(err_bad), 64'd1);
    chk("t5_bit9b", 64'(free_map[9]), 64'd0);

    // 6: flush ignores ports and keeps errors; reset beats flush
    do_reset();
    for (int c = 1; c < 16; c++) begin
      avld = 4'hF; for (int k = 0; k < 4; k++) ai[k] = 6'(4 * c + k);
      cycle();
    end
    idle(); avld = 4'h1; ai[0] = 63; cycle(); idle();
    chk("t6_map0f", free_map, 64'h0F);
    chk("t6_bad_pre", 64'(err_bad), 64'd1);
    flush = 1; avld = 4'hF; rvld = 4'hF;
    for (int k = 0; k < 4; k++) begin ai[k] = 6'(k); ri[k] = 6'(k); end
    cycle(); idle();
    chk("t6_map", free_map, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_cnt", 64'(free_cnt), 64'd64);
    chk("t6_errs", 64'({err_dbl, err_bad}), 64'b01);
    flush = 1; rst = 1; cycle(); idle();
    chk("t6_rst_errs", 64'({err_dbl, err_bad}), 64'd0);

    // Randomized traffic, mostly legal with occasional misuse, flush and reset
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] used_a, used_r;
      idle();
      used_a = '0; used_r = '0;
      avld = 4'($urandom_range(15));
      rvld = 4'($urandom_range(15));
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(19) != 0) ai[k] = pick(m_map, 1'b1, used_a);
        used_a[ai[k]] = 1'b1;
        if ($urandom_range(19) != 0) ri[k] = pick(m_map, 1'b0, used_r);
        used_r[ri[k]] = 1'b1;
      end
      flush = ($urandom_range(59) == 0);
      rst   = ($urandom_range(199) == 0);
      cycle();
      $display("txn %0d rst=%0d flush=%0d avld=%h rvld=%h map=%h cnt=%0d", n, rst, flush, avld, rvld, free_map, free_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
